// File: rtl/window_gen.sv
// window_gen: streaming WIN_W x WIN_H neighbourhood generator with line buffers,
// zero/replicate border handling, ready/valid flow control and end-of-frame flush.
module window_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int WIN_W      = 3,
    parameter int WIN_H      = 3,
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080,
    parameter int PAD_MODE   = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic [7:0]                          in_user,
    input  logic                                in_valid,
    output logic                                out_ready,
    output logic [DATA_WIDTH*WIN_W*WIN_H-1:0]   out_data,
    output logic [7:0]                          out_user,
    output logic                                out_valid,
    input  logic                                in_ready
);
    localparam int RW  = WIN_W / 2;
    localparam int RH  = WIN_H / 2;
    localparam int PW  = DATA_WIDTH + 8;
    localparam int CW  = $clog2(IMG_WIDTH);
    localparam int RWD = $clog2(IMG_HEIGHT + WIN_H) + 1;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state, state_n;

    logic [CW-1:0]  col, ox, pc, col_n, ox_n;
    logic [RWD-1:0] row, oy, pr, row_n, oy_n;
    logic [PW-1:0]  lb [WIN_H-1][IMG_WIDTH];
    logic [PW-1:0]  sr [WIN_H][WIN_W];
    logic [PW-1:0]  sr_n [WIN_H][WIN_W];
    logic [PW-1:0]  v [WIN_H];
    logic [PW-1:0]  e;
    logic           accept, restart, step, produce, valid_n, pad;
    int             xs, ys, cx, cy;
    logic [DATA_WIDTH*WIN_W*WIN_H-1:0] win_n;

    always_comb begin
        out_ready = state == IDLE || (state != FLUSH && (!out_valid || in_ready));
        accept    = in_valid && out_ready;
        restart   = accept && in_user[0];
        step      = state == FLUSH ? (!out_valid || in_ready) : accept && (restart || state != IDLE);
        pc        = restart ? '0 : col;
        pr        = restart ? '0 : row;
        produce   = step && !restart && (state == RUN || state == FLUSH ||
                    (state == FILL && pc == CW'(RW) && pr == RWD'(RH)));
        col_n     = pc == CW'(IMG_WIDTH-1) ? '0 : pc + 1'b1;
        row_n     = pc == CW'(IMG_WIDTH-1) ? pr + 1'b1 : pr;
        ox_n      = ox == CW'(IMG_WIDTH-1) ? '0 : ox + 1'b1;
        oy_n      = ox == CW'(IMG_WIDTH-1) ? oy + 1'b1 : oy;
        valid_n   = produce || (out_valid && !in_ready);
        state_n   = restart ? FILL
                  : (state == FILL && produce) ? RUN
                  : (state == RUN && accept && pc == CW'(IMG_WIDTH-1) && pr == RWD'(IMG_HEIGHT-1)) ? FLUSH
                  : (state == FLUSH && produce && ox == CW'(IMG_WIDTH-1) && oy == RWD'(IMG_HEIGHT-1)) ? IDLE
                  : state;
    end

    // Column vector at the current input column, oldest row first; flush feeds don't-care pixels.
    always_comb begin
        for (int y = 0; y < WIN_H-1; y++) v[y] = lb[y][pc];
        v[WIN_H-1] = state == FLUSH ? '0 : {in_user, in_data};
        for (int y = 0; y < WIN_H; y++) begin
            for (int x = 0; x < WIN_W-1; x++) sr_n[y][x] = sr[y][x+1];
            sr_n[y][WIN_W-1] = v[y];
        end
    end

    // Out-of-image elements hold stale or wrapped columns/rows; redirect them to the clamped
    // in-window element, which is always present in the shifted window.
    always_comb begin
        win_n = '0;
        e     = '0;
        xs    = 0;
        ys    = 0;
        cx    = 0;
        cy    = 0;
        pad   = 1'b0;
        for (int y = 0; y < WIN_H; y++) begin
            for (int x = 0; x < WIN_W; x++) begin
                xs  = int'(ox) + x - RW;
                ys  = int'(oy) + y - RH;
                cx  = xs < 0 ? RW - int'(ox) : xs > IMG_WIDTH-1 ? IMG_WIDTH-1 - int'(ox) + RW : x;
                cy  = ys < 0 ? RH - int'(oy) : ys > IMG_HEIGHT-1 ? IMG_HEIGHT-1 - int'(oy) + RH : y;
                pad = xs < 0 || xs > IMG_WIDTH-1 || ys < 0 || ys > IMG_HEIGHT-1;
                e   = '0;
                for (int j = 0; j < WIN_H; j++)
                    for (int i = 0; i < WIN_W; i++)
                        if (j == cy && i == cx) e = sr_n[j][i];
                win_n[(WIN_W*y+x)*DATA_WIDTH +: DATA_WIDTH] = (PAD_MODE == 0 && pad) ? '0 : e[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            ox        <= '0;
            oy        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_user  <= '0;
        end else begin
            state     <= state_n;
            out_valid <= valid_n;
            if (step) begin
                col <= col_n;
                row <= row_n;
            end
            if (restart) begin
                ox <= '0;
                oy <= '0;
            end else if (produce) begin
                ox       <= ox_n;
                oy       <= oy_n;
                out_data <= win_n;
                out_user <= sr_n[RH][RW][PW-1:DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (step) begin
            for (int y = 0; y < WIN_H-1; y++) lb[y][pc] <= v[y+1];
            sr <= sr_n;
        end
    end
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed checks of window_gen on a 4x3 image, zero and replicate padding.
module tb_window_gen;
    logic         clk = 0, reset = 0, in_valid = 0, in_ready = 1;
    logic [15:0]  in_data = '0;
    logic [7:0]   in_user = '0;
    logic [143:0] d0, d1;
    logic [7:0]   uo0, uo1;
    logic         v0, v1, ready0, ready1;
    logic [143:0] q0[$], q1[$];
    logic [7:0]   qu[$];
    int           errs = 0, checks = 0;

    window_gen #(.DATA_WIDTH(16), .WIN_W(3), .WIN_H(3), .IMG_WIDTH(4), .IMG_HEIGHT(3), .PAD_MODE(0)) u0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_user(in_user), .in_valid(in_valid),
        .out_ready(ready0), .out_data(d0), .out_user(uo0), .out_valid(v0), .in_ready(in_ready));
    window_gen #(.DATA_WIDTH(16), .WIN_W(3), .WIN_H(3), .IMG_WIDTH(4), .IMG_HEIGHT(3), .PAD_MODE(1)) u1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_user(in_user), .in_valid(in_valid),
        .out_ready(ready1), .out_data(d1), .out_user(uo1), .out_valid(v1), .in_ready(in_ready));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && in_ready) begin
            if (v0) begin
                q0.push_back(d0);
                qu.push_back(uo0);
            end
            if (v1) q1.push_back(d1);
        end
    end

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [143:0] model(input int ox, input int oy, input int pm);
        logic [143:0] w = '0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++) begin
                int c = ox + x - 1, r = oy + y - 1, val;
                bit p = c < 0 || c > 3 || r < 0 || r > 2;
                c = c < 0 ? 0 : c > 3 ? 3 : c;
                r = r < 0 ? 0 : r > 2 ? 2 : r;
                val = (pm == 0 && p) ? 0 : 4*r + c + 1;
                w[(3*y+x)*16 +: 16] = 16'(val);
            end
        return w;
    endfunction

    function automatic logic [143:0] pk(input int e[9]);
        logic [143:0] w = '0;
        for (int i = 0; i < 9; i++) w[i*16 +: 16] = 16'(e[i]);
        return w;
    endfunction

    task automatic clear_q();
        q0.delete();
        q1.delete();
        qu.delete();
    endtask

    task automatic push(input int d, input bit sof);
        int n = 0;
        in_data  = 16'(d);
        in_user  = {7'b0, sof};
        in_valid = 1;
        @(negedge clk);
        while (!ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        in_user  = '0;
    endtask

    task automatic send_frame(input int stall_at);
        for (int k = 0; k < 12; k++) begin
            if (k == stall_at) begin
                in_data  = 16'(k + 1);
                in_user  = '0;
                in_valid = 1;
                in_ready = 0;
                for (int s = 0; s < 3; s++) begin
                    int idx;
                    @(negedge clk);
                    idx = q0.size();
                    chk($sformatf("stall%0d_valid", s), v0, 1);
                    chk($sformatf("stall%0d_ready", s), ready0, 0);
                    chk($sformatf("stall%0d_data", s), d0, model(idx % 4, idx / 4, 0));
                    @(posedge clk);
                    #1;
                end
                in_ready = 1;
            end
            push(k + 1, k == 0);
        end
    endtask

    task automatic check_frame(input string tag);
        int lo = 0, n = 0;
        @(negedge clk);
        while (!ready0 && lo < 50) begin
            lo++;
            @(negedge clk);
        end
        chk({tag, "_flush_cycles"}, lo, 5);
        while ((q0.size() < 12 || q1.size() < 12) && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_count0"}, q0.size(), 12);
        chk({tag, "_count1"}, q1.size(), 12);
        for (int i = 0; i < 12 && i < q0.size() && i < q1.size(); i++) begin
            chk($sformatf("%s_pad0_w%0d", tag, i), q0[i], model(i % 4, i / 4, 0));
            chk($sformatf("%s_pad1_w%0d", tag, i), q1[i], model(i % 4, i / 4, 1));
            chk($sformatf("%s_user_w%0d", tag, i), qu[i], (i == 0) ? 1 : 0);
        end
    endtask

    initial begin
        #1 reset = 1;
        #1;
        chk("rst_valid0", v0, 0);
        chk("rst_valid1", v1, 0);
        chk("rst_data", d0, 0);
        chk("rst_user", uo0, 0);
        chk("rst_ready", ready0, 1);
        repeat (2) @(negedge clk);
        reset = 0;
        chk("post_rst_ready", ready0, 1);

        clear_q();
        for (int k = 0; k < 6; k++) push(20 + k, 0);
        repeat (4) @(negedge clk);
        chk("idle_discard", q0.size(), 0);

        clear_q();
        send_frame(-1);
        check_frame("base");
        chk("pad0_first", q0.size() > 0 ? q0[0] : '0, pk('{0,0,0, 0,1,2, 0,5,6}));
        chk("pad1_first", q1.size() > 0 ? q1[0] : '0, pk('{1,1,2, 1,1,2, 5,5,6}));
        chk("pad1_last", q1.size() > 11 ? q1[11] : '0, pk('{7,8,8, 11,12,12, 11,12,12}));

        clear_q();
        send_frame(8);
        check_frame("stall");

        clear_q();
        push(1, 1);
        for (int k = 1; k < 5; k++) push(k + 1, 0);
        chk("abort_partial_none", q0.size(), 0);
        clear_q();
        send_frame(-1);
        check_frame("abort");

        clear_q();
        send_frame(-1);
        @(negedge clk);
        chk("flush_valid_before_rst", v0, 1);
        reset = 1;
        #1;
        chk("flush_rst_valid0", v0, 0);
        chk("flush_rst_valid1", v1, 0);
        chk("flush_rst_ready", ready0, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        clear_q();
        for (int k = 0; k < 6; k++) push(30 + k, 0);
        repeat (4) @(negedge clk);
        chk("rst_discard_count", q0.size(), 0);
        chk("rst_discard_valid", v0, 0);
        clear_q();
        send_frame(-1);
        check_frame("post_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 Parameter DATA_WIDTH, 16, pixel width in bits.
REQ-002 Parameter WIN_W, 3, window width; odd, 3..7.
REQ-003 Parameter WIN_H, 3, window height; odd, 3..7.
REQ-004 Parameter IMG_WIDTH, 1920, pixels per line; must be >= WIN_W.
REQ-005 Parameter IMG_HEIGHT, 1080, lines per frame; must be >= WIN_H.
REQ-006 Parameter PAD_MODE, 1, border fill: 0 = zero, 1 = replicate (clamp).
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 in_data  input  DATA_WIDTH  upstream pixel.
REQ-010 in_user  input  8  sideband; bit0 = start of frame (SOF).
REQ-011 in_valid  input  1  upstream pixel valid.
REQ-012 out_ready  output  1  block accepts a pixel this cycle.
REQ-013 out_data  output  DATA_WIDTH x (WIN_W*WIN_H)  window; element index = WIN_W*y + x, y=0 is top row, x=0 is left column.
REQ-014 out_user  output  8  in_user of the window centre pixel.
REQ-015 out_valid  output  1  window valid.
REQ-016 in_ready  input  1  downstream accepts the window.

Function
REQ-017 Definitions: RW = WIN_W/2 and RH = WIN_H/2. Accept = in_valid & out_ready. Transfer = out_valid & in_ready.
REQ-018 Line storage holds WIN_H-1 lines of IMG_WIDTH pixels. Each entry stores data and user.
REQ-019 Input counters col and row track each accepted pixel. On an accepted SOF, col=0 and row=0 for that pixel.
REQ-020 States IDLE, FILL, RUN and FLUSH.
- IDLE: out_ready=1. Non-SOF pixels are accepted and discarded. An accepted SOF moves to FILL.
- FILL: accepts pixels and produces no output. It moves to RUN on acceptance of pixel (col=RW, row=RH); that acceptance also produces window (0,0).
- RUN: each acceptance produces exactly one window. After acceptance of (IMG_WIDTH-1, IMG_HEIGHT-1), the block moves to FLUSH.
- FLUSH: out_ready=0. The block internally generates the remaining RH*IMG_WIDTH+RW windows, then returns to IDLE.
REQ-021 Output position (ox,oy) advances in raster order from (0,0) to (IMG_WIDTH-1, IMG_HEIGHT-1). Exactly IMG_WIDTH*IMG_HEIGHT windows are produced per frame.
REQ-022 Window element (x,y) sources image pixel (ox+x-RW, oy+y-RH).
- Coordinate outside the image, PAD_MODE=0: the element is 0.
- Coordinate outside the image, PAD_MODE=1: the coordinate is clamped independently per axis to [0,IMG_WIDTH-1] and [0,IMG_HEIGHT-1].
REQ-023 out_user equals the stored in_user of pixel (ox,oy). It is never padded.
REQ-024 Outputs are registered. out_data, out_user and out_valid change only on clk edges.
- Latency: the window is valid on the cycle after the acceptance (or, in FLUSH, the generation step) that completes it.
REQ-025 Backpressure, FILL/RUN: out_ready = ~out_valid | in_ready.
REQ-026 Backpressure, FLUSH: generation advances only when ~out_valid | in_ready.
REQ-027 While out_valid=1 and in_ready=0, out_data, out_user and out_valid hold stable. No window is dropped or duplicated.
REQ-028 An accepted SOF in FILL or RUN aborts the current frame. The partial frame's pending window is discarded, the SOF pixel becomes (0,0) and the state becomes FILL.
REQ-029 FLUSH cannot be interrupted by SOF because out_ready=0.
REQ-030 Column wrap: col=IMG_WIDTH-1 wraps to 0 and increments row. The output position wraps identically.

Reset
REQ-031 While reset=1, asynchronously and immediately: state=IDLE; col, row, ox and oy = 0; out_valid=0; out_data all 0; out_user=0.
REQ-032 out_ready is driven combinationally from state per REQ-020 and REQ-025, so it reads 1 (IDLE) during and after reset.
REQ-033 Line storage contents are not reset. Stale contents never reach out_data, because masking and padding reference only current-frame coordinates.
REQ-034 Reset asserted mid-frame or mid-FLUSH discards all pending windows. After release, no output occurs until a new SOF.

Verification
REQ-035 Use WIN_W=WIN_H=3, IMG_WIDTH=4, IMG_HEIGHT=3, pixel(c,r)=4r+c+1, SOF on pixel 1, in_ready=1.
- PAD_MODE=0: first window = [0,0,0, 0,1,2, 0,5,6], out_user[0]=1.
REQ-036 Same stimulus with PAD_MODE=1:
- first window = [1,1,2, 1,1,2, 5,5,6];
- last window = [7,8,8, 11,12,12, 11,12,12].
REQ-037 Same frame: exactly 12 windows are produced and out_user[0]=1 only on the first.
- out_ready is low for the 5 FLUSH-generation cycles, then IDLE is reached.
REQ-038 Hold in_ready=0 for 3 cycles mid-RUN with in_valid=1:
- out_data and out_valid are stable and out_ready=0 for those cycles;
- the window sequence is identical to the unstalled run.
REQ-039 Apply SOF after 6 pixels, then a full frame: the first 6 pixels produce no windows, and the new frame yields the REQ-035 results exactly.
REQ-040 Assert reset while in FLUSH:
- out_valid=0 with no clk edge;
- after release, non-SOF pixels are discarded;
- the next SOF frame is correct.
